// File: rtl/div_rtl_pkg.sv
// rtl/div_rtl_pkg.sv - shared constants, state encoding and helpers for the restoring divider
package div_rtl_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Iteration counter must index 0..W-1; keep at least one bit for W=1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift {P,QS} left, trial-subtract divisor
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_p,
    input  logic [W-1:0] i_qs,
    input  logic [W-1:0] i_dr,
    output logic [W:0]   o_p,
    output logic [W-1:0] o_qs
);

    logic [W+1:0] w_p_shifted;
    logic [W:0]   w_trial;
    logic         w_fits;

    assign w_p_shifted = {i_p, i_qs[W-1]};
    // Compare at full width so the trial sign never depends on a wrapped difference.
    assign w_fits      = (w_p_shifted >= {2'b00, i_dr});
    assign w_trial     = w_p_shifted[W:0] - {1'b0, i_dr};

    assign o_p  = w_fits ? w_trial : w_p_shifted[W:0];
    assign o_qs = {i_qs[W-2:0], w_fits};

endmodule

// File: rtl/div_rtl.sv
// rtl/div_rtl.sv - sequential restoring divider, 2W/W bits, one quotient bit per clock
module div_rtl
    import div_rtl_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [2*W-1:0] N,
    input  logic [W-1:0]   D,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           Busy,
    output logic           Stop,
    output logic           DivErr
);

    localparam int CW = cnt_width(W);

    state_t        r_state;
    state_t        w_next_state;
    logic [W:0]    r_p;
    logic [W-1:0]  r_qs;
    logic [W-1:0]  r_dr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_diverr;

    logic          w_accept;
    logic          w_invalid;
    logic          w_last;
    logic [W:0]    w_p_next;
    logic [W-1:0]  w_qs_next;

    // Quotient fits in W bits only when the dividend's high half is below the divisor.
    assign w_invalid = (D == '0) || (N[2*W-1:W] >= D);
    assign w_last    = (r_cnt == CW'(W - 1));

    div_step #(.W(W)) u_step (
        .i_p  (r_p),
        .i_qs (r_qs),
        .i_dr (r_dr),
        .o_p  (w_p_next),
        .o_qs (w_qs_next)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        Busy         = 1'b0;
        Stop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_invalid ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                Stop = 1'b1;
                if (Start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_invalid ? S_DONE : S_CALC;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_p      <= '0;
            r_qs     <= '0;
            r_dr     <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_diverr <= 1'b0;
        end else if (w_accept) begin
            if (w_invalid) begin
                r_q      <= '1;
                r_r      <= '1;
                r_diverr <= 1'b1;
            end else begin
                r_p      <= {1'b0, N[2*W-1:W]};
                r_qs     <= N[W-1:0];
                r_dr     <= D;
                r_cnt    <= '0;
                r_diverr <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_p   <= w_p_next;
            r_qs  <= w_qs_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_q <= w_qs_next;
                r_r <= w_p_next[W-1:0];
            end
        end
    end

    assign Q      = r_q;
    assign R      = r_r;
    assign DivErr = r_diverr;

endmodule

// File: tb/tb_div_rtl.sv
// tb/tb_div_rtl.sv - directed and randomized self-checking bench for div_rtl
module tb_div_rtl;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic           Start = 1'b0;
    logic [2*W-1:0] N = '0;
    logic [W-1:0]   D = '0;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           Busy;
    logic           Stop;
    logic           DivErr;

    int tests   = 0;
    int fails   = 0;
    int overlap = 0;

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Busy && Stop) overlap++;

    div_rtl #(.W(W)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .N      (N),
        .D      (D),
        .Q      (Q),
        .R      (R),
        .Busy   (Busy),
        .Stop   (Stop),
        .DivErr (DivErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // lat counts edges after the accepting edge until Stop is seen.
    task automatic run(input logic [2*W-1:0] n, input logic [W-1:0] d,
                       output int lat, output int busy, output logic stop0);
        N = n;
        D = d;
        Start = 1'b1;
        step();
        Start = 1'b0;
        stop0 = Stop;
        lat = 0;
        busy = 0;
        while (!Stop && lat < 40) begin
            if (Busy) busy++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy;
        logic stop0;
        logic [W-1:0] rd;
        logic [W-1:0] rhi;
        logic [W-1:0] rlo;

        // reset state
        step();
        step();
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_r", 32'(R), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_stop", 32'(Stop), 32'h0);
        chk("rst_diverr", 32'(DivErr), 32'h0);
        Rst = 1'b1;
        step();
        chk("idle_stop", 32'(Stop), 32'h0);

        // 100 / 7
        run(16'd100, 8'd7, lat, busy, stop0);
        chk("t1_lat", 32'(lat), 32'd8);
        chk("t1_busy_cycles", 32'(busy), 32'd8);
        chk("t1_q", 32'(Q), 32'd14);
        chk("t1_r", 32'(R), 32'd2);
        chk("t1_diverr", 32'(DivErr), 32'h0);

        // maximum valid quotient, issued back-to-back from DONE
        run(16'hFEFF, 8'hFF, lat, busy, stop0);
        chk("t2_stop_drop", 32'(stop0), 32'h0);
        chk("t2_lat", 32'(lat), 32'd8);
        chk("t2_q", 32'(Q), 32'hFF);
        chk("t2_r", 32'(R), 32'hFE);

        // divide by zero
        run(16'd1234, 8'd0, lat, busy, stop0);
        chk("t3_lat", 32'(lat), 32'd0);
        chk("t3_busy", 32'(Busy), 32'h0);
        chk("t3_diverr", 32'(DivErr), 32'h1);
        chk("t3_q", 32'(Q), 32'hFF);
        chk("t3_r", 32'(R), 32'hFF);

        // quotient overflow, then a valid request from DONE
        run(16'h0100, 8'd1, lat, busy, stop0);
        chk("t4_lat", 32'(lat), 32'd0);
        chk("t4_busy", 32'(Busy), 32'h0);
        chk("t4_diverr", 32'(DivErr), 32'h1);
        chk("t4_q", 32'(Q), 32'hFF);
        run(16'd9, 8'd3, lat, busy, stop0);
        chk("t4b_stop_drop", 32'(stop0), 32'h0);
        chk("t4b_lat", 32'(lat), 32'd8);
        chk("t4b_diverr", 32'(DivErr), 32'h0);
        chk("t4b_q", 32'(Q), 32'd3);
        chk("t4b_r", 32'(R), 32'd0);

        // asynchronous reset in the middle of CALC
        N = 16'd500;
        D = 8'd9;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        chk("t5_busy_before", 32'(Busy), 32'h1);
        Rst = 1'b0;
        #1;
        chk("t5_rst_q", 32'(Q), 32'h0);
        chk("t5_rst_r", 32'(R), 32'h0);
        chk("t5_rst_busy", 32'(Busy), 32'h0);
        chk("t5_rst_stop", 32'(Stop), 32'h0);
        chk("t5_rst_diverr", 32'(DivErr), 32'h0);
        step();
        step();
        chk("t5_no_stop", 32'(Stop), 32'h0);
        Rst = 1'b1;
        step();
        chk("t5_idle_stop", 32'(Stop), 32'h0);
        run(16'd500, 8'd9, lat, busy, stop0);
        chk("t5_lat", 32'(lat), 32'd8);
        chk("t5_q", 32'(Q), 32'd55);
        chk("t5_r", 32'(R), 32'd5);

        // Start re-pulsed during CALC with different operands
        N = 16'd1000;
        D = 8'd37;
        Start = 1'b1;
        step();
        Start = 1'b0;
        lat = 0;
        step();
        step();
        N = 16'd50;
        D = 8'd5;
        Start = 1'b1;
        step();
        Start = 1'b0;
        lat = 3;
        while (!Stop && lat < 40) begin
            step();
            lat++;
        end
        chk("t6_lat", 32'(lat), 32'd8);
        chk("t6_q", 32'(Q), 32'd27);
        chk("t6_r", 32'(R), 32'd1);
        chk("t6_diverr", 32'(DivErr), 32'h0);

        // random valid pairs against the arithmetic invariant
        for (int i = 0; i < 1000; i++) begin
            rd  = 8'($urandom_range(255, 1));
            rhi = 8'($urandom_range(32'(rd) - 1, 0));
            rlo = 8'($urandom_range(255, 0));
            run({rhi, rlo}, rd, lat, busy, stop0);
            chk("rand_invariant", 32'(Q) * 32'(rd) + 32'(R), 32'({rhi, rlo}));
            chk("rand_r_lt_d", 32'(R < rd), 32'h1);
        end

        chk("busy_stop_exclusive", 32'(overlap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_rtl.md
# div_rtl

Sequential restoring divider: divides a 2W-bit unsigned dividend by a W-bit unsigned divisor and returns a W-bit quotient and a W-bit remainder, one quotient bit per clock. It is the inverse datapath of the shift-add multiplier. It exposes the same Start/Stop handshake, so either unit can sit behind the same sequencer in the arithmetic lab design.

## Interface
Parameters:
- W, default 8: operand width; dividend is 2W bits, quotient and remainder are W bits each.

Ports:
- Clk  input  1  system clock, rising-edge active. This is the only clock.
- Rst  input  1  asynchronous reset, active-low.
- Start  input  1  request a division; sampled only in IDLE and DONE.
- N  input  2W  unsigned dividend; sampled on the accepting edge.
- D  input  W  unsigned divisor; sampled on the accepting edge.
- Q  output  W  quotient register.
- R  output  W  remainder register.
- Busy  output  1  high while iterating.
- Stop  output  1  high while the result is valid (DONE state).
- DivErr  output  1  high in DONE when the last request was invalid.

## Operation
- Datapath registers:
  - P (W+1 bits): partial remainder.
  - QS (W bits): dividend low half, shifted into the quotient.
  - DR (W bits): divisor copy.
  - CNT: counts 0..W-1.
- FSM states:
  - IDLE: Busy=0, Stop=0. Start=1 → check operands:
    - If D==0 or N[2W-1:W] ≥ D, the quotient overflows W bits. Go to DONE with DivErr=1, Q=all-ones, R=all-ones.
    - Otherwise load P={0,N[2W-1:W]}, QS=N[W-1:0], DR=D, CNT=0, DivErr=0, and go to CALC.
  - CALC: Busy=1. Each cycle:
    - Shift {P,QS} left by 1.
    - Compute trial = P_shifted − {0,DR}, in W+1 bits.
    - If trial ≥ 0: P=trial and QS[0]=1. Otherwise P is unchanged and QS[0]=0.
    - CNT increments. When CNT==W-1, go to DONE, loading Q=QS_new and R=P_new[W-1:0].
  - DONE: Stop=1, Busy=0. Q, R and DivErr are held.
    - Start=1 is accepted exactly as in IDLE (back-to-back operation).
    - Start=0 keeps the FSM in DONE. Results stay until the next accepted Start.
- Start during CALC is ignored. No queuing.
- N and D are don't-care outside the accepting edge.
- Arithmetic invariant for valid requests: N == Q·D + R, with R < D.

## Timing
- Reset (Rst=0, any time, including mid-CALC): state goes to IDLE immediately. Q=0, R=0, P=0, QS=0, CNT=0, Busy=0, Stop=0, DivErr=0.
- A partial computation is discarded on reset, and no Stop is issued for it.
- Start sampled high at edge k, valid request: Busy=1 after k; W iterations on edges k+1..k+W; Stop=1 and results valid after edge k+W, i.e. W cycles of latency (8 for W=8).
- Invalid request at edge k: Stop=1 and DivErr=1 after edge k, i.e. 1-cycle latency; Busy never asserts.
- Back-to-back: Start held high in DONE at edge j → Stop drops after edge j, and the new result appears after edge j+W.
- Throughput: one result per W+1 cycles when Start is held high continuously.
- Busy and Stop are never high together.

## Structure
- Shared package:
  - State encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Default width constant WIDTH=8.
  - Counter width: clog2(W).
- Sub-module div_step, combinational: takes P, QS and DR; returns the shifted, conditionally subtracted P and QS. Instantiated once.
- FSM, counter and registers live in div_rtl.

## Test plan
- N=100, D=7, Start pulse → after 8 cycles Stop=1, Q=14, R=2, DivErr=0. Busy is high for exactly those 8 cycles.
- N=16'hFEFF, D=8'hFF → Q=8'hFF, R=8'hFE. This is the maximum valid quotient.
- D=0, N=1234 → Stop=1 one cycle after Start, DivErr=1, Q=8'hFF, R=8'hFF. Busy stays 0.
- N=16'h0100, D=1 (overflow) → DivErr=1 with the same one-cycle response. Then N=9, D=3 issued from DONE → DivErr=0, Q=3, R=0.
- Rst pulled low at the 4th CALC cycle of N=500, D=9 → all outputs 0 at once and IDLE. A new Start after release gives Q=55, R=5.
- Start re-pulsed during CALC → ignored; the original result is unchanged. Also run 1000 random valid (N, D) pairs checking N==Q·D+R and R<D.
